// File: rtl/snake_cmd_exec_if.sv
// Draw-command execution port bundle: command stream in, framebuffer writes
// and the paired line/char command handshake out.
interface snake_cmd_exec_if #(
  parameter int unsigned H_LOGIC_WIDTH  = 5,
  parameter int unsigned V_LOGIC_WIDTH  = 5,
  parameter int unsigned COLOR_ID_WIDTH = 8
);

  logic [31:0]                          cmd;
  logic                                 cmd_vld;
  logic                                 fb_we;
  logic [V_LOGIC_WIDTH+H_LOGIC_WIDTH-1:0] fb_addr;
  logic [COLOR_ID_WIDTH-1:0]            fb_data;
  logic [31:0]                          aux_cmd0;
  logic [31:0]                          aux_cmd1;
  logic                                 aux_vld;
  logic                                 aux_rdy;
  logic                                 busy;
  logic                                 ovf;
  logic                                 err;

  // Producer / testbench side
  modport master (
    output cmd, cmd_vld, aux_rdy,
    input  fb_we, fb_addr, fb_data, aux_cmd0, aux_cmd1, aux_vld, busy, ovf, err
  );

  // Executor side
  modport slave (
    input  cmd, cmd_vld, aux_rdy,
    output fb_we, fb_addr, fb_data, aux_cmd0, aux_cmd1, aux_vld, busy, ovf, err
  );

endinterface

// File: rtl/snake_cmd_exec.sv
// Snake draw-command executor. Buffers the core's command stream in a FIFO,
// turns pixel/rectangle commands into framebuffer writes and pairs two-word
// line/char commands for the downstream engine.
// Optional statistics counters: define SNAKE_CMD_EXEC_STAT_EN.
module snake_cmd_exec #(
  parameter int unsigned H_LOGIC_WIDTH  = 5,
  parameter int unsigned V_LOGIC_WIDTH  = 5,
  parameter logic [H_LOGIC_WIDTH-1:0] H_LOGIC_MAX = 5'd31,
  parameter logic [V_LOGIC_WIDTH-1:0] V_LOGIC_MAX = 5'd23,
  parameter int unsigned COLOR_ID_WIDTH = 8,
  parameter int unsigned FIFO_DEPTH     = 16,
  parameter int unsigned FIFO_AW        = 4
) (
  input  logic        clk,
  input  logic        rst,
`ifdef SNAKE_CMD_EXEC_STAT_EN
  output logic [15:0] stat_cmds,
  output logic [15:0] stat_drops,
`endif
  snake_cmd_exec_if.slave bus
);

  localparam int unsigned AW = V_LOGIC_WIDTH + H_LOGIC_WIDTH;

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StDecode  = 2'd1;
  localparam logic [1:0] StFill    = 2'd2;
  localparam logic [1:0] StAuxWait = 2'd3;

  // Zero-extended limits so range checks stay meaningful at full coordinate width
  localparam logic [H_LOGIC_WIDTH:0] HMaxExt = {1'b0, H_LOGIC_MAX};
  localparam logic [V_LOGIC_WIDTH:0] VMaxExt = {1'b0, V_LOGIC_MAX};

  // ---------------------------------------------------------------------------
  // Command FIFO
  // ---------------------------------------------------------------------------
  logic [31:0]      mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0] wptr_q, rptr_q;
  logic [FIFO_AW:0] count_q;
  logic [31:0]      rd_q;
  logic             full, empty, push, pop, fifo_drop;

  assign full      = count_q[FIFO_AW];
  assign empty     = (count_q == '0);
  // A full FIFO drops the word even if a pop frees a slot on the same edge
  assign push      = bus.cmd_vld & ~full;
  assign fifo_drop = bus.cmd_vld & full;

  // Storage write; contents need no reset
  always_ff @(posedge clk) begin
    if (push) mem[wptr_q] <= bus.cmd;
  end

  // Pointers, occupancy and registered read port
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      rd_q    <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + {{(FIFO_AW-1){1'b0}}, 1'b1};
      if (pop) begin
        rptr_q <= rptr_q + {{(FIFO_AW-1){1'b0}}, 1'b1};
        rd_q   <= mem[rptr_q];
      end
      unique case ({push, pop})
        2'b10:   count_q <= count_q + {{FIFO_AW{1'b0}}, 1'b1};
        2'b01:   count_q <= count_q - {{FIFO_AW{1'b0}}, 1'b1};
        default: count_q <= count_q;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Decode fields of the word just read
  // ---------------------------------------------------------------------------
  logic [3:0]                op;
  logic [H_LOGIC_WIDTH-1:0]  p_x, r_x0, r_x1, x1_clip;
  logic [V_LOGIC_WIDTH-1:0]  p_y, r_y0, r_y1, y1_clip;
  logic [COLOR_ID_WIDTH-1:0] p_col, r_col;

  assign op    = rd_q[31:28];
  assign p_x   = rd_q[27:23];
  assign p_y   = rd_q[22:18];
  assign p_col = rd_q[17:10];
  assign r_x0  = rd_q[27:23];
  assign r_y0  = rd_q[22:18];
  assign r_x1  = rd_q[17:13];
  assign r_y1  = rd_q[12:8];
  assign r_col = rd_q[7:0];

  assign x1_clip = ({1'b0, r_x1} > HMaxExt) ? H_LOGIC_MAX : r_x1;
  assign y1_clip = ({1'b0, r_y1} > VMaxExt) ? V_LOGIC_MAX : r_y1;

  // ---------------------------------------------------------------------------
  // Execution FSM
  // ---------------------------------------------------------------------------
  logic [1:0]                state_q, state_d;
  logic [H_LOGIC_WIDTH-1:0]  cx_q, cx_d, x0_q, x0_d, x1_q, x1_d;
  logic [V_LOGIC_WIDTH-1:0]  cy_q, cy_d, y1_q, y1_d;
  logic [COLOR_ID_WIDTH-1:0] col_q, col_d;
  logic [31:0]               latch_q, latch_d;
  logic                      latch_vld_q, latch_vld_d;
  logic                      fb_we_q, fb_we_d;
  logic [AW-1:0]             fb_addr_q, fb_addr_d;
  logic [COLOR_ID_WIDTH-1:0] fb_data_q, fb_data_d;
  logic [31:0]               aux_cmd0_q, aux_cmd0_d, aux_cmd1_q, aux_cmd1_d;
  logic                      aux_vld_q, aux_vld_d;
  logic                      ovf_q, err_q, err_set;
  logic [1:0]                cmd_inc, drop_inc;

  // Next-state, write generation and pair handling
  always_comb begin
    state_d     = state_q;
    cx_d        = cx_q;
    cy_d        = cy_q;
    x0_d        = x0_q;
    x1_d        = x1_q;
    y1_d        = y1_q;
    col_d       = col_q;
    latch_d     = latch_q;
    latch_vld_d = latch_vld_q;
    fb_we_d     = 1'b0;
    fb_addr_d   = fb_addr_q;
    fb_data_d   = fb_data_q;
    aux_cmd0_d  = aux_cmd0_q;
    aux_cmd1_d  = aux_cmd1_q;
    aux_vld_d   = aux_vld_q;
    err_set     = 1'b0;
    pop         = 1'b0;
    cmd_inc     = 2'd0;
    drop_inc    = 2'd0;

    unique case (state_q)
      StIdle: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = StDecode;
        end
      end
      StDecode: begin
        state_d = StIdle;
        unique case (op)
          4'h0: begin
            if (({1'b0, p_x} <= HMaxExt) && ({1'b0, p_y} <= VMaxExt)) begin
              fb_we_d   = 1'b1;
              fb_addr_d = {p_y, p_x};
              fb_data_d = p_col;
              cmd_inc   = 2'd1;
            end else begin
              err_set  = 1'b1;
              drop_inc = 2'd1;
            end
          end
          4'h1: begin
            if ((r_x0 > x1_clip) || (r_y0 > y1_clip)) begin
              err_set  = 1'b1;
              drop_inc = 2'd1;
            end else begin
              cx_d    = r_x0;
              cy_d    = r_y0;
              x0_d    = r_x0;
              x1_d    = x1_clip;
              y1_d    = y1_clip;
              col_d   = r_col;
              cmd_inc = 2'd1;
              state_d = StFill;
            end
          end
          4'h9, 4'ha: begin
            if (!rd_q[0]) begin
              // A newer first word replaces an unpaired one
              if (latch_vld_q) begin
                err_set  = 1'b1;
                drop_inc = 2'd1;
              end
              latch_d     = rd_q;
              latch_vld_d = 1'b1;
            end else if (latch_vld_q && (latch_q[31:28] == op)) begin
              aux_cmd0_d = latch_q;
              aux_cmd1_d = rd_q;
              aux_vld_d  = 1'b1;
              cmd_inc    = 2'd2;
              state_d    = StAuxWait;
            end else begin
              err_set     = 1'b1;
              drop_inc    = latch_vld_q ? 2'd2 : 2'd1;
              latch_vld_d = 1'b0;
            end
          end
          default: begin
            err_set  = 1'b1;
            drop_inc = 2'd1;
          end
        endcase
      end
      StFill: begin
        fb_we_d   = 1'b1;
        fb_addr_d = {cy_q, cx_q};
        fb_data_d = col_q;
        if (cx_q == x1_q) begin
          cx_d = x0_q;
          if (cy_q == y1_q) state_d = StIdle;
          else              cy_d = cy_q + {{(V_LOGIC_WIDTH-1){1'b0}}, 1'b1};
        end else begin
          cx_d = cx_q + {{(H_LOGIC_WIDTH-1){1'b0}}, 1'b1};
        end
      end
      StAuxWait: begin
        if (bus.aux_rdy) begin
          aux_vld_d   = 1'b0;
          latch_vld_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and registered outputs; sticky flags clear only on reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cx_q        <= '0;
      cy_q        <= '0;
      x0_q        <= '0;
      x1_q        <= '0;
      y1_q        <= '0;
      col_q       <= '0;
      latch_q     <= '0;
      latch_vld_q <= 1'b0;
      fb_we_q     <= 1'b0;
      fb_addr_q   <= '0;
      fb_data_q   <= '0;
      aux_cmd0_q  <= '0;
      aux_cmd1_q  <= '0;
      aux_vld_q   <= 1'b0;
      ovf_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cx_q        <= cx_d;
      cy_q        <= cy_d;
      x0_q        <= x0_d;
      x1_q        <= x1_d;
      y1_q        <= y1_d;
      col_q       <= col_d;
      latch_q     <= latch_d;
      latch_vld_q <= latch_vld_d;
      fb_we_q     <= fb_we_d;
      fb_addr_q   <= fb_addr_d;
      fb_data_q   <= fb_data_d;
      aux_cmd0_q  <= aux_cmd0_d;
      aux_cmd1_q  <= aux_cmd1_d;
      aux_vld_q   <= aux_vld_d;
      ovf_q       <= ovf_q | fifo_drop;
      err_q       <= err_q | err_set;
    end
  end

  assign bus.fb_we    = fb_we_q;
  assign bus.fb_addr  = fb_addr_q;
  assign bus.fb_data  = fb_data_q;
  assign bus.aux_cmd0 = aux_cmd0_q;
  assign bus.aux_cmd1 = aux_cmd1_q;
  assign bus.aux_vld  = aux_vld_q;
  assign bus.ovf      = ovf_q;
  assign bus.err      = err_q;
  assign bus.busy     = (state_q != StIdle) | ~empty;

`ifdef SNAKE_CMD_EXEC_STAT_EN
  logic [15:0] stat_cmds_q, stat_drops_q;
  logic [16:0] cmds_sum, drops_sum;

  assign cmds_sum  = {1'b0, stat_cmds_q} + {15'b0, cmd_inc};
  assign drops_sum = {1'b0, stat_drops_q} + {15'b0, drop_inc} + {16'b0, fifo_drop};

  // Saturating activity counters
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_cmds_q  <= '0;
      stat_drops_q <= '0;
    end else begin
      stat_cmds_q  <= cmds_sum[16] ? 16'hffff : cmds_sum[15:0];
      stat_drops_q <= drops_sum[16] ? 16'hffff : drops_sum[15:0];
    end
  end

  assign stat_cmds  = stat_cmds_q;
  assign stat_drops = stat_drops_q;
`else
  logic unused_stat;
  assign unused_stat = ^{cmd_inc, drop_inc};
`endif

endmodule
